asp: RTL and testbench

- Application-specific protocol bridge between a host port and a tagged network link.
- Host → network: checks the parity of each host word, prepends a sequence tag, and holds the frame on the network link until it is acknowledged.
- Network → host: strips the tag from each incoming frame, delivers the data to the host, and returns a one-cycle ACK.
- Sits between the host interface logic and the network transceiver.

---
 rtl/asp.sv | 109 ++++++++++
 tb/tb_asp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/asp.sv
// Host/network protocol bridge: parity-checked host words go out as tagged frames held until
// ACKed; incoming tagged frames are stripped and delivered to the host with a one-cycle ACK.
module asp #(
  parameter int unsigned data_size = 32,
  parameter int unsigned tag_size  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_parity_ready_in,
  input  logic [data_size:0]            data_parity_in,
  input  logic                          network_data_ready_in,
  input  logic                          network_ACK_in,
  input  logic [data_size+tag_size-1:0] network_data_tag_in,
  output logic                          parity_error_out,
  output logic                          host_data_ready_out,
  output logic [data_size-1:0]          host_data_out,
  output logic                          network_data_ready_out,
  output logic                          network_ACK_out,
  output logic [data_size+tag_size-1:0] network_data_tag_out
);

  typedef enum logic [0:0] {StIdle, StWaitAck} tx_state_e;

  tx_state_e                     tx_state_q, tx_state_d;
  logic [tag_size-1:0]           tag_cnt_q, tag_cnt_d;
  logic                          net_ready_q, net_ready_d;
  logic [data_size+tag_size-1:0] net_tag_q, net_tag_d;
  logic                          parity_err_q, parity_err_d;
  logic                          rx_prev_q, rx_prev_d;
  logic [data_size-1:0]          host_data_q, host_data_d;
  logic                          host_ready_q, host_ready_d;
  logic                          ack_out_q, ack_out_d;
  logic                          rx_accept;

  // TX path: host words are only looked at while no frame is outstanding.
  always_comb begin
    tx_state_d   = tx_state_q;
    tag_cnt_d    = tag_cnt_q;
    net_ready_d  = net_ready_q;
    net_tag_d    = net_tag_q;
    parity_err_d = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (data_parity_ready_in) begin
          if (^data_parity_in) begin
            parity_err_d = 1'b1;
          end else begin
            net_tag_d   = {tag_cnt_q, data_parity_in[data_size-1:0]};
            net_ready_d = 1'b1;
            tx_state_d  = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        if (network_ACK_in) begin
          net_ready_d = 1'b0;
          tag_cnt_d   = tag_cnt_q + 1'b1;
          tx_state_d  = StIdle;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // RX path: accept only on the rising level of the incoming valid.
  assign rx_accept = network_data_ready_in & ~rx_prev_q;

  always_comb begin
    rx_prev_d    = network_data_ready_in;
    host_ready_d = rx_accept;
    ack_out_d    = rx_accept;
    host_data_d  = host_data_q;
    if (rx_accept) begin
      host_data_d = network_data_tag_in[data_size-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= StIdle;
      tag_cnt_q    <= '0;
      net_ready_q  <= 1'b0;
      net_tag_q    <= '0;
      parity_err_q <= 1'b0;
      rx_prev_q    <= 1'b0;
      host_data_q  <= '0;
      host_ready_q <= 1'b0;
      ack_out_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tag_cnt_q    <= tag_cnt_d;
      net_ready_q  <= net_ready_d;
      net_tag_q    <= net_tag_d;
      parity_err_q <= parity_err_d;
      rx_prev_q    <= rx_prev_d;
      host_data_q  <= host_data_d;
      host_ready_q <= host_ready_d;
      ack_out_q    <= ack_out_d;
    end
  end

  assign parity_error_out       = parity_err_q;
  assign host_data_ready_out    = host_ready_q;
  assign host_data_out          = host_data_q;
  assign network_data_ready_out = net_ready_q;
  assign network_ACK_out        = ack_out_q;
  assign network_data_tag_out   = net_tag_q;

endmodule

// File: tb/tb_asp.sv
// Bench for asp: directed scenarios plus random traffic, checked against a transaction-level
// model of the bridge (outstanding-frame flag, tag counter, last delivered word).
module tb_asp;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             dp_rdy;
  logic [DW:0]      dp;
  logic             n_rdy;
  logic             n_ack;
  logic [DW+TW-1:0] n_frame;
  logic             par_err;
  logic             h_rdy;
  logic [DW-1:0]    h_data;
  logic             o_rdy;
  logic             o_ack;
  logic [DW+TW-1:0] o_frame;

  always #5 clk = ~clk;

  asp #(.data_size(DW), .tag_size(TW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .data_parity_ready_in  (dp_rdy),
    .data_parity_in        (dp),
    .network_data_ready_in (n_rdy),
    .network_ACK_in        (n_ack),
    .network_data_tag_in   (n_frame),
    .parity_error_out      (par_err),
    .host_data_ready_out   (h_rdy),
    .host_data_out         (h_data),
    .network_data_ready_out(o_rdy),
    .network_ACK_out       (o_ack),
    .network_data_tag_out  (o_frame)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int unsigned      m_tag;
  bit               m_busy;
  logic [DW+TW-1:0] m_frame;
  logic [DW-1:0]    m_host;
  bit               m_prev;
  bit               m_perr;
  bit               m_hrdy;
  bit               m_ack;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tag = 0; m_busy = 0; m_frame = '0; m_host = '0; m_prev = 0;
    m_perr = 0; m_hrdy = 0; m_ack = 0;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".net_ready"}, 64'(o_rdy), 64'(m_busy));
    check({ctx, ".net_frame"}, 64'(o_frame), 64'(m_frame));
    check({ctx, ".parity_err"}, 64'(par_err), 64'(m_perr));
    check({ctx, ".host_ready"}, 64'(h_rdy), 64'(m_hrdy));
    check({ctx, ".host_data"}, 64'(h_data), 64'(m_host));
    check({ctx, ".net_ack"}, 64'(o_ack), 64'(m_ack));
  endtask

  // Apply one cycle of inputs, advance the model by one transaction step, compare everything.
  task automatic cycle(input string ctx, input logic d_r, input logic [DW:0] d,
                       input logic ack, input logic nr, input logic [DW+TW-1:0] nf);
    dp_rdy = d_r; dp = d; n_ack = ack; n_rdy = nr; n_frame = nf;
    @(posedge clk);
    #1;
    m_perr = 0; m_hrdy = 0; m_ack = 0;
    if (!m_busy) begin
      if (d_r) begin
        if (^d) m_perr = 1;
        else begin
          m_frame = {m_tag[TW-1:0], d[DW-1:0]};
          m_busy  = 1;
        end
      end
    end else if (ack) begin
      m_busy = 0;
      m_tag  = (m_tag + 1) % (1 << TW);
    end
    if (nr && !m_prev) begin
      m_host = nf[DW-1:0];
      m_hrdy = 1;
      m_ack  = 1;
    end
    m_prev = nr;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    cycle(ctx, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [DW:0] good_word(input logic [DW-1:0] d);
    return {^d, d};
  endfunction

  // Reset asserted away from the clock edge; outputs must clear without waiting for a clock.
  task automatic async_reset(input string ctx);
    #2;
    reset = 1'b1;
    dp_rdy = 0; dp = '0; n_ack = 0; n_rdy = 0; n_frame = '0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    dp_rdy = 0; dp = '0; n_ack = 0; n_rdy = 0; n_frame = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // ACK while idle does nothing
    cycle("ack_idle0", 1'b0, '0, 1'b1, 1'b0, '0);
    cycle("ack_idle1", 1'b0, '0, 1'b1, 1'b0, '0);

    cycle("tx0", 1'b1, 33'h1_0000_0001, 1'b0, 1'b0, '0);
    check("tx0.frame_const", 64'(o_frame), 64'h00_0000_0001);
    check("tx0.ready_const", 64'(o_rdy), 64'h1);
    cycle("tx0_hold", 1'b0, '0, 1'b0, 1'b0, '0);
    cycle("tx0_ack", 1'b0, '0, 1'b1, 1'b0, '0);
    check("tx0_ack.ready_const", 64'(o_rdy), 64'h0);
    check("tx0_ack.frame_kept", 64'(o_frame), 64'h00_0000_0001);
    cycle("tx1", 1'b1, 33'h0_0000_0003, 1'b0, 1'b0, '0);
    check("tx1.frame_const", 64'(o_frame), 64'h01_0000_0003);
    cycle("tx1_ack", 1'b0, '0, 1'b1, 1'b0, '0);

    // Parity error: one-cycle pulse, nothing sent
    cycle("perr", 1'b1, 33'h0_0000_0001, 1'b0, 1'b0, '0);
    check("perr.pulse_const", 64'(par_err), 64'h1);
    idle("perr_after");
    check("perr_after.pulse_const", 64'(par_err), 64'h0);
    cycle("tx2", 1'b1, good_word(32'h1234_5678), 1'b0, 1'b0, '0);
    check("tx2.tag_const", 64'(o_frame[DW+TW-1:DW]), 64'h02);
    cycle("tx2_ack", 1'b0, '0, 1'b1, 1'b0, '0);

    // RX with ready held for three cycles
    for (int i = 0; i < 3; i++) cycle("rx_hold", 1'b0, '0, 1'b0, 1'b1, 40'hAB_DEAD_BEEF);
    check("rx.data_const", 64'(h_data), 64'hDEAD_BEEF);
    idle("rx_drop");

    // Full tag wrap, with a host word offered during WAIT_ACK each time
    async_reset("reset2");
    for (int i = 0; i < 256; i++) begin
      cycle("wrap_tx", 1'b1, good_word($urandom), 1'b0, 1'b0, '0);
      if (i == 0 || i == 255) check("wrap.tag_const", 64'(o_frame[DW+TW-1:DW]), 64'(i));
      cycle("wrap_ignored", 1'b1, good_word($urandom), 1'b0, 1'b0, '0);
      cycle("wrap_ack", 1'b0, '0, 1'b1, 1'b0, '0);
    end
    cycle("wrap_257", 1'b1, good_word(32'hCAFE_F00D), 1'b0, 1'b0, '0);
    check("wrap_257.frame_const", 64'(o_frame), 64'h00_CAFE_F00D);

    // Reset while waiting for ACK abandons the frame
    async_reset("reset_waitack");
    cycle("post_reset_tx", 1'b1, good_word(32'h0BAD_CAFE), 1'b0, 1'b0, '0);
    check("post_reset.tag_const", 64'(o_frame[DW+TW-1:DW]), 64'h00);
    cycle("post_reset_ack", 1'b0, '0, 1'b1, 1'b0, '0);

    // Random concurrent TX/RX traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      logic [DW:0]   w;
      d = $urandom;
      w = good_word(d);
      if ($urandom_range(3) == 0) w[DW] = ~w[DW];
      cycle("rand", 1'($urandom_range(1)), w, 1'($urandom_range(2) == 0),
            1'($urandom_range(1)), {8'($urandom), 32'($urandom)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
